// File: rtl/cmp_search.sv
// Successive-approximation searcher driving the y side of an external
// combinational comparator and converging on its hidden x operand.
module cmp_search #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             ug,
  input  logic             ul,
  input  logic             sg,
  input  logic             sl,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       probes
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [WIDTH:0]   ONE_X      = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] U_INIT     = WIDTH'(HI_INIT >> 1);
  localparam logic [3:0]       MAX_PROBES = 4'(WIDTH + 1);
  // Flipping the MSB maps the unsigned index onto offset-binary, so index
  // order matches two's-complement order in signed mode.
  localparam logic [WIDTH-1:0] SIGN_MASK  =
    (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] u;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   hi;

  logic             gt;
  logic             lt;
  logic             one_hot;
  logic             guard;
  logic [WIDTH:0]   u_ext;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;
  logic [WIDTH-1:0] mid_up;
  logic [WIDTH-1:0] mid_dn;
  logic [3:0]       cnt_next;

  assign busy = (state == PROBE);

  // NOTE: every signal is assigned on every pass through always_comb, so no latch is inferred.
  always_comb begin
    gt       = (SIGNED != 0) ? sg : ug;
    lt       = (SIGNED != 0) ? sl : ul;
    one_hot  = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
    u_ext    = {1'b0, u};
    sum_up   = u_ext + ONE_X + hi;
    sum_dn   = lo + u_ext - ONE_X;
    mid_up   = WIDTH'(sum_up >> 1);
    mid_dn   = WIDTH'(sum_dn >> 1);
    cnt_next = {1'b0, probes} + 4'd1;
    guard    = (cnt_next > MAX_PROBES);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the synchronous
  // reset clears every register including the search bounds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      u      <= '0;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      probes <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= HI_INIT;
            u      <= U_INIT;
            guess  <= U_INIT ^ SIGN_MASK;
            probes <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            state  <= PROBE;
          end
        end

        PROBE: begin
          if (guard) begin
            err   <= 1'b1;
            found <= 1'b0;
            state <= DONE;
          end else begin
            probes <= cnt_next[2:0];
            if (!one_hot) begin
              err   <= 1'b1;
              found <= 1'b0;
              state <= DONE;
            end else if (eq) begin
              result <= guess;
              found  <= 1'b1;
              state  <= DONE;
            end else if (gt) begin
              if (u_ext == hi) begin
                found <= 1'b0;
                state <= DONE;
              end else begin
                lo    <= u_ext + ONE_X;
                u     <= mid_up;
                guess <= mid_up ^ SIGN_MASK;
              end
            end else begin
              if (u_ext == lo) begin
                found <= 1'b0;
                state <= DONE;
              end else begin
                hi    <= u_ext - ONE_X;
                u     <= mid_dn;
                guess <= mid_dn ^ SIGN_MASK;
              end
            end
          end
        end

        DONE: begin
          // Completion pulse lands one edge after the final probe.
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search: an unsigned and a signed instance, each
// driven by a bench-side comparator, checked against a plain binary-search model.
module tb_cmp_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_u = 1'b0, start_s = 1'b0;
  logic [3:0] target_u = '0, target_s = '0;
  int         mode_u = 0, mode_s = 0;

  logic [3:0] guess_u, guess_s, result_u, result_s;
  logic [2:0] probes_u, probes_s;
  logic       ug_u, ul_u, sg_u, sl_u, eq_u;
  logic       ug_s, ul_s, sg_s, sl_s, eq_s;
  logic       busy_u, done_u, found_u, err_u;
  logic       busy_s, done_s, found_s, err_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] guess;
    logic       busy;
    logic       done;
    logic       found;
    logic       err;
    logic [3:0] result;
    logic [2:0] probes;
  } obs_t;

  always #5 clk = ~clk;

  // Comparator environment. mode 0: honest, 1: gt and lt both high,
  // 2: stuck reporting target<guess, 3: all flags low.
  function automatic logic [4:0] cmp_flags(input logic [3:0] t, input logic [3:0] g, input int mode);
    case (mode)
      1:       return 5'b11110;
      2:       return 5'b01010;
      3:       return 5'b00000;
      default: return {t > g, t < g, $signed(t) > $signed(g), $signed(t) < $signed(g), t == g};
    endcase
  endfunction

  assign {ug_u, ul_u, sg_u, sl_u, eq_u} = cmp_flags(target_u, guess_u, mode_u);
  assign {ug_s, ul_s, sg_s, sl_s, eq_s} = cmp_flags(target_s, guess_s, mode_s);

  cmp_search #(.WIDTH(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .guess(guess_u),
    .ug(ug_u), .ul(ul_u), .sg(sg_u), .sl(sl_u), .eq(eq_u),
    .busy(busy_u), .done(done_u), .found(found_u), .err(err_u),
    .result(result_u), .probes(probes_u)
  );

  cmp_search #(.WIDTH(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .guess(guess_s),
    .ug(ug_s), .ul(ul_s), .sg(sg_s), .sl(sl_s), .eq(eq_s),
    .busy(busy_s), .done(done_s), .found(found_s), .err(err_s),
    .result(result_s), .probes(probes_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input bit sgn);
    obs_t o;
    if (sgn) o = '{guess_s, busy_s, done_s, found_s, err_s, result_s, probes_s};
    else     o = '{guess_u, busy_u, done_u, found_u, err_u, result_u, probes_u};
    return o;
  endfunction

  task automatic set_start(input bit sgn, input logic v);
    if (sgn) start_s = v;
    else     start_u = v;
  endtask

  // Reference: textbook binary search over the integer range with floor midpoints.
  task automatic ref_search(input bit sgn, input logic [3:0] t, input int mode,
                            output logic [3:0] gq[$], output int np, output bit f, output bit e);
    int lo, hi, mid, tv, rel;
    gq = {};
    np = 0;
    f  = 1'b0;
    e  = 1'b0;
    lo = sgn ? -8 : 0;
    hi = sgn ? 7 : 15;
    tv = sgn ? int'($signed(t)) : int'(t);
    while (lo <= hi) begin
      mid = (lo + hi) >>> 1;
      gq.push_back(4'(mid));
      np++;
      if (mode == 1 || mode == 3) begin
        e = 1'b1;
        return;
      end
      rel = (mode == 2) ? -1 : (tv > mid) ? 1 : (tv < mid) ? -1 : 0;
      if (rel == 0) begin
        f = 1'b1;
        return;
      end
      if (rel > 0) lo = mid + 1;
      else         hi = mid - 1;
    end
  endtask

  task automatic do_search(input bit sgn, input logic [3:0] t, input int mode,
                           input bit inject, input string tag);
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int         np, edges, busy_n;
    bit         f, e, seen;
    obs_t       o;

    ref_search(sgn, t, mode, exp_q, np, f, e);
    if (sgn) begin target_s = t; mode_s = mode; end
    else     begin target_u = t; mode_u = mode; end

    @(negedge clk);
    set_start(sgn, 1'b1);
    @(negedge clk);
    set_start(sgn, 1'b0);

    edges  = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      o = snap(sgn);
      if (o.done) begin
        seen = 1'b1;
        break;
      end
      if (o.busy) begin
        busy_n++;
        got_q.push_back(o.guess);
      end
      set_start(sgn, inject && (c == 1));
      @(negedge clk);
      edges++;
    end
    set_start(sgn, 1'b0);

    o = snap(sgn);
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(np + 1));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(np));
    check({tag, " n_guesses"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s guess[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " probes"}, 32'(o.probes), 32'(np));
    check({tag, " found"}, 32'(o.found), 32'(f));
    check({tag, " err"}, 32'(o.err), 32'(e));
    check({tag, " busy_at_done"}, 32'(o.busy), 32'd0);
    if (f) check({tag, " result"}, 32'(o.result), 32'(t));

    @(negedge clk);
    o = snap(sgn);
    check({tag, " done_one_cycle"}, 32'(o.done), 32'd0);
    check({tag, " found_held"}, 32'(o.found), 32'(f));
    if (sgn) mode_s = 0;
    else     mode_u = 0;
  endtask

  initial begin
    obs_t o;
    bit   saw_done;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = snap(s[0]);
      check($sformatf("reset_state[%0d]", s), 32'(o), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    do_search(1'b0, 4'd5,    0, 1'b0, "u_t5");
    do_search(1'b0, 4'd15,   0, 1'b0, "u_t15");
    do_search(1'b0, 4'd0,    0, 1'b0, "u_t0");
    do_search(1'b1, 4'b1000, 0, 1'b0, "s_tm8");
    do_search(1'b1, 4'b0111, 0, 1'b0, "s_tp7");
    do_search(1'b0, 4'd9,    1, 1'b0, "u_bad_both");
    do_search(1'b0, 4'd9,    3, 1'b0, "u_bad_none");
    do_search(1'b1, 4'd3,    1, 1'b0, "s_bad_both");
    do_search(1'b0, 4'd9,    2, 1'b0, "u_stuck_lt");
    do_search(1'b1, 4'd9,    2, 1'b0, "s_stuck_lt");
    do_search(1'b0, 4'd11,   0, 1'b1, "u_start_in_probe");
    do_search(1'b1, 4'b1101, 0, 1'b1, "s_start_in_probe");

    // Reset during the second probe abandons the search without a done pulse.
    target_u = 4'd9;
    mode_u   = 0;
    @(negedge clk);
    start_u = 1'b1;
    @(negedge clk);
    start_u = 1'b0;
    @(negedge clk);
    check("midrst busy_before", 32'(busy_u), 32'd1);
    check("midrst probes_before", 32'(probes_u), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    o = snap(1'b0);
    check("midrst outputs_cleared", 32'(o), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      saw_done |= done_u;
    end
    check("midrst no_done", 32'(saw_done), 32'd0);
    check("midrst stays_idle", 32'(busy_u), 32'd0);

    for (int n = 0; n < 30; n++) begin
      bit         sg_sel;
      logic [3:0] tv;
      sg_sel = 1'($urandom_range(0, 1));
      tv     = 4'($urandom_range(0, 15));
      do_search(sg_sel, tv, 0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
